// File: rtl/rand_range_sampler_if.sv
// Request/response bundle between game logic and the range sampler.
// The master side (game logic) issues bounds and consumes results;
// the slave side (the sampler) answers them.
interface rand_range_sampler_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_bound;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_value;
  logic             rsp_fallback;
  logic             rsp_err;

  modport master (
    output req_valid, req_bound, rsp_ready,
    input  req_ready, rsp_valid, rsp_value, rsp_fallback, rsp_err
  );

  modport slave (
    input  req_valid, req_bound, rsp_ready,
    output req_ready, rsp_valid, rsp_value, rsp_fallback, rsp_err
  );
endinterface

// File: rtl/rand_range_sampler.sv
// Turns the 32-bit LFSR word into a uniform value in [0, bound) using
// mask-and-reject sampling. The LFSR is only enabled while a draw is in
// progress, and every evaluation waits DRAW_CYCLES enabled cycles so the
// sampled window holds fresh bits. After MAX_TRIES rejections the last
// candidate is folded back into range (cand - bound) and flagged.
module rand_range_sampler #(
  parameter int WIDTH       = 16,
  parameter int DRAW_CYCLES = 18,
  parameter int MAX_TRIES   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rand_in,
  output logic        rand_en,
  rand_range_sampler_if.slave bus
);

  localparam int GAP_W = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(DRAW_CYCLES - 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bound_q, bound_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             fallback_q, fallback_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] cand;
  logic             unused_rand;

  // Only the low WIDTH bits are sampled; the rest of the LFSR word is ignored.
  assign unused_rand = ^(rand_in >> WIDTH);

  // Smallest all-ones pattern covering x: propagate the top set bit rightwards.
  function automatic logic [WIDTH-1:0] smear_right(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = x;
    for (int s = 1; s < WIDTH; s = s * 2) begin
      r = r | (r >> s);
    end
    return r;
  endfunction

  assign cand             = rand_in[WIDTH-1:0] & mask_q;
  assign bus.req_ready    = (state_q == IDLE);
  assign rand_en          = (state_q == SAMPLE);
  assign bus.rsp_valid    = (state_q == DONE);
  assign bus.rsp_value    = value_q;
  assign bus.rsp_fallback = fallback_q;
  assign bus.rsp_err      = err_q;

  // State and datapath registers; reset drops any in-flight request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bound_q    <= '0;
      mask_q     <= '0;
      gap_q      <= '0;
      tries_q    <= '0;
      value_q    <= '0;
      fallback_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bound_q    <= bound_d;
      mask_q     <= mask_d;
      gap_q      <= gap_d;
      tries_q    <= tries_d;
      value_q    <= value_d;
      fallback_q <= fallback_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: accept, count down to each evaluation, accept/reject/fold.
  always_comb begin
    state_d    = state_q;
    bound_d    = bound_q;
    mask_d     = mask_q;
    gap_d      = gap_q;
    tries_d    = tries_q;
    value_d    = value_q;
    fallback_d = fallback_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          bound_d    = bus.req_bound;
          mask_d     = smear_right(bus.req_bound - 1'b1);
          gap_d      = GAP_LOAD;
          tries_d    = '0;
          value_d    = '0;
          fallback_d = 1'b0;
          err_d      = 1'b0;
          if (bus.req_bound == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (cand < bound_q) begin
          value_d = cand;
          state_d = DONE;
        end else if (tries_q == TRY_LAST) begin
          value_d    = cand - bound_q;
          fallback_d = 1'b1;
          state_d    = DONE;
        end else begin
          tries_d = tries_q + 1'b1;
          gap_d   = GAP_LOAD;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
